mix_columns_engine: RTL and testbench

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

---
 rtl/aes_pkg.sv | 36 +++
 rtl/mix_columns_engine_if.sv | 40 ++++
 rtl/mix_column_unit.sv | 47 ++++
 rtl/mix_columns_engine.sv | 90 +++++++++
 tb/tb_mix_columns_engine.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES MixColumns types, widths and GF(2^8) helpers.
// InvMixColumns support is enabled by defining MIX_COLUMNS_INV_EN.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // constant multipliers used here all fit in 4 bits
  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [3:0] k
  );
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Handshake bundle between a state producer/consumer and the engine.
// inv_sel only exists when MIX_COLUMNS_INV_EN is defined.
interface mix_columns_engine_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [0:STATE_W-1] state_in;
  logic               out_valid;
  logic               out_ready;
  logic [0:STATE_W-1] state_out;
`ifdef MIX_COLUMNS_INV_EN
  logic               inv_sel;
`endif

  modport master (
`ifdef MIX_COLUMNS_INV_EN
    output inv_sel,
`endif
    output in_valid,
    output state_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  state_out
  );

  modport slave (
`ifdef MIX_COLUMNS_INV_EN
    input  inv_sel,
`endif
    input  in_valid,
    input  state_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output state_out
  );

endinterface

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns transform.
// Inverse path (inv input) only built with MIX_COLUMNS_INV_EN.
module mix_column_unit
  import aes_pkg::*;
(
`ifdef MIX_COLUMNS_INV_EN
  input  logic             inv,
`endif
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [COL_W-1:0] fwd;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign fwd = {
    gf_mul(a0, 4'd2) ^ gf_mul(a1, 4'd3) ^ a2 ^ a3,
    a0 ^ gf_mul(a1, 4'd2) ^ gf_mul(a2, 4'd3) ^ a3,
    a0 ^ a1 ^ gf_mul(a2, 4'd2) ^ gf_mul(a3, 4'd3),
    gf_mul(a0, 4'd3) ^ a1 ^ a2 ^ gf_mul(a3, 4'd2)
  };

`ifdef MIX_COLUMNS_INV_EN
  logic [COL_W-1:0] rev;

  assign rev = {
    gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^
    gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9),
    gf_mul(a0, 4'd9) ^ gf_mul(a1, 4'd14) ^
    gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13),
    gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9) ^
    gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11),
    gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^
    gf_mul(a2, 4'd9) ^ gf_mul(a3, 4'd14)
  };

  assign col_out = inv ? rev : fwd;
`else
  assign col_out = fwd;
`endif

endmodule

// File: rtl/mix_columns_engine.sv
// Multi-cycle AES MixColumns engine, COLS_PER_CYCLE columns per cycle.
// Define MIX_COLUMNS_INV_EN to add inv_sel / InvMixColumns.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic                clk,
  input logic                rst,
  mix_columns_engine_if.slave bus
);

  localparam int NCYC = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(NCYC - 1);

  if (!(COLS_PER_CYCLE == 1 ||
        COLS_PER_CYCLE == 2 ||
        COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e             state_q;
  state_e             state_d;
  logic [1:0]         cnt_q;
  logic [0:STATE_W-1] work_q;
  logic [0:STATE_W-1] res_q;
  logic               accept;
  logic [1:0]         idx     [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_out [COLS_PER_CYCLE];
`ifdef MIX_COLUMNS_INV_EN
  logic               inv_q;
`endif

  assign accept = bus.in_valid && (state_q == IDLE);

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    assign idx[i] = 2'(int'(cnt_q) * COLS_PER_CYCLE + i);

    mix_column_unit u_col (
`ifdef MIX_COLUMNS_INV_EN
      .inv     (inv_q),
`endif
      .col_in  (work_q[{idx[i], 5'd0} +: COL_W]),
      .col_out (col_out[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (cnt_q == LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      work_q <= '0;
      res_q  <= '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q  <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q  <= '0;
      work_q <= bus.state_in;
`ifdef MIX_COLUMNS_INV_EN
      inv_q  <= bus.inv_sel;
`endif
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 2'd1;
      // only the columns of this cycle are overwritten
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
        res_q[{idx[i], 5'd0} +: COL_W] <= col_out[i];
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.state_out = res_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench: three engines (1, 2, 4 columns/cycle) driven in lockstep.
// Inverse scenarios run when MIX_COLUMNS_INV_EN is defined.
module tb_mix_columns_engine;
  import aes_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               out_ready;
  logic [0:STATE_W-1] state_in;
`ifdef MIX_COLUMNS_INV_EN
  logic               inv_sel;
`endif

  logic [2:0]         ov;
  logic [2:0]         ir;
  logic [0:STATE_W-1] so [3];

  int checks = 0;
  int errors = 0;

  localparam logic [0:127] ST1 =
    {32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c};
  localparam logic [0:127] EX1 =
    {32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8};
  localparam logic [0:127] ST2 =
    {32'h01010101, 32'hc6c6c6c6, 32'h2d26314c, 32'hdb135345};
  localparam logic [0:127] EX2 =
    {32'h01010101, 32'hc6c6c6c6, 32'h4d7ebdf8, 32'h8e4da1bc};
  localparam logic [0:127] ST3 =
    {32'hffffffff, 32'h00000000, 32'hf20a225c, 32'hd4d4d4d5};
  localparam logic [0:127] EX3 =
    {32'hffffffff, 32'h00000000, 32'h9fdc589d, 32'hd5d5d7d6};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_engine_if bus ();

    assign bus.in_valid  = in_valid;
    assign bus.state_in  = state_in;
    assign bus.out_ready = out_ready;
`ifdef MIX_COLUMNS_INV_EN
    assign bus.inv_sel   = inv_sel;
`endif
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign so[g] = bus.state_out;

    mix_columns_engine #(
      .COLS_PER_CYCLE (1 << g)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
`ifdef MIX_COLUMNS_INV_EN
    inv_sel   = 1'b0;
`endif
    repeat (2) step();
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ir[g] !== 1'b1 || ov[g] !== 1'b0 || so[g] !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: ir=%b ov=%b so=%h, want ir=1 ov=0 so=0",
                 g, ir[g], ov[g], so[g]);
      end
    end
  endtask

  task automatic run_txn(
    input logic [0:127] st,
    input logic [0:127] exp,
    input logic         inv
  );
`ifdef MIX_COLUMNS_INV_EN
    inv_sel = inv;
`endif
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ir[g] !== 1'b1) begin
        errors++;
        $display("FAIL idle_before dut%0d: in_ready=%b want 1", g, ir[g]);
      end
    end
    in_valid  = 1'b1;
    state_in  = st;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
    inv_sel  = ~inv;
`endif
    state_in = ~st;
    for (int k = 1; k <= 4; k++) begin
      step();
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (ov[g] !== (k >= (4 >> g))) begin
          errors++;
          $display("FAIL latency dut%0d cyc%0d: out_valid=%b want %b",
                   g, k, ov[g], (k >= (4 >> g)));
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (so[g] !== exp || ir[g] !== 1'b0) begin
        errors++;
        $display("FAIL result dut%0d: so=%h ir=%b, want so=%h ir=0",
                 g, so[g], ir[g], exp);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ov[g] !== 1'b0 || ir[g] !== 1'b1 || so[g] !== exp) begin
        errors++;
        $display("FAIL release dut%0d: ov=%b ir=%b so=%h, want 0 1 %h",
                 g, ov[g], ir[g], so[g], exp);
      end
    end
  endtask

  task automatic test_forward();
    run_txn(ST1, EX1, 1'b0);
    run_txn(ST2, EX2, 1'b0);
    run_txn(ST3, EX3, 1'b0);
    run_txn('0, '0, 1'b0);
  endtask

  task automatic test_stall();
    in_valid = 1'b1;
    state_in = ST1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      state_in = ST2;
      step();
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (ov[g] !== 1'b1 || ir[g] !== 1'b0 || so[g] !== EX1) begin
          errors++;
          $display("FAIL stall dut%0d c%0d: ov=%b ir=%b so=%h, want 1 0 %h",
                   g, c, ov[g], ir[g], so[g], EX1);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    run_txn(ST3, EX3, 1'b0);
  endtask

  task automatic test_reset_busy();
    in_valid = 1'b1;
    state_in = ST2;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ir[g] !== 1'b1 || ov[g] !== 1'b0 || so[g] !== '0) begin
        errors++;
        $display("FAIL rst_busy dut%0d: ir=%b ov=%b so=%h, want 1 0 0",
                 g, ir[g], ov[g], so[g]);
      end
    end
    run_txn(ST1, EX1, 1'b0);
  endtask

`ifdef MIX_COLUMNS_INV_EN
  task automatic test_inverse();
    logic [0:127] st;
    logic [0:127] mid;
    run_txn(EX1, ST1, 1'b1);
    run_txn(EX2, ST2, 1'b1);
    for (int n = 0; n < 100; n++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      inv_sel  = 1'b0;
      in_valid = 1'b1;
      state_in = st;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      mid = so[0];
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      inv_sel  = 1'b1;
      in_valid = 1'b1;
      state_in = mid;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (ov[g] !== 1'b1 || so[g] !== st) begin
          errors++;
          $display("FAIL roundtrip dut%0d n%0d: ov=%b so=%h want %h",
                   g, n, ov[g], so[g], st);
        end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_stall();
    test_reset_busy();
`ifdef MIX_COLUMNS_INV_EN
    test_inverse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
